// File: rtl/bc_to_num_decoder.sv
// Serial 11-module barcode reader: frames, validates and decodes to a 4-bit number.
// Optional BC_TIMEOUT_EN macro enables the inter-module gap timeout.
module bc_to_num_decoder #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scan_valid,
  input  logic        scan_bit,
  output logic [3:0]  num,
  output logic        num_valid,
  output logic        err,
  output logic        busy,
  output logic [10:0] bc
);

  typedef enum logic [1:0] {IDLE, SHIFT, DECODE} state_t;

  state_t      state, state_nxt;
  logic [10:0] frame, frame_nxt, frame_shift;
  logic [3:0]  count, count_nxt, count_inc;
  logic [3:0]  num_nxt, dec_num;
  logic [10:0] bc_nxt;
  logic        num_valid_nxt, err_nxt, busy_nxt, dec_ok;

`ifdef BC_TIMEOUT_EN
  logic [7:0]  gap, gap_nxt;
`else
  logic        unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  assign frame_shift = {frame[9:0], scan_bit};
  assign count_inc   = (count == 4'd11) ? count : count + 4'd1;

  // Guard/stop/Manchester check on the frame as it will look after this module.
  always_comb begin
    dec_ok  = (frame_shift[10:9] == 2'b10) && frame_shift[0];
    dec_num = '0;
    for (int i = 0; i < 4; i++) begin
      dec_ok     = dec_ok && (frame_shift[2*i+2] ^ frame_shift[2*i+1]);
      dec_num[i] = frame_shift[2*i+2];
    end
  end

  // Results are registered on the edge that accepts the last module, so the
  // pulse lines up with the single DECODE cycle.
  always_comb begin
    state_nxt     = state;
    frame_nxt     = frame;
    count_nxt     = count;
    num_nxt       = num;
    bc_nxt        = bc;
    num_valid_nxt = 1'b0;
    err_nxt       = 1'b0;
`ifdef BC_TIMEOUT_EN
    gap_nxt       = gap;
`endif
    case (state)
      IDLE: begin
        if (scan_valid && scan_bit) begin
          frame_nxt = 11'd1;
          count_nxt = 4'd1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (scan_valid) begin
          frame_nxt = frame_shift;
          count_nxt = count_inc;
`ifdef BC_TIMEOUT_EN
          gap_nxt   = '0;
`endif
          if (count_inc == 4'd11) begin
            state_nxt = DECODE;
            bc_nxt    = frame_shift;
            if (dec_ok) begin
              num_nxt       = dec_num;
              num_valid_nxt = 1'b1;
            end else begin
              err_nxt = 1'b1;
            end
          end
        end
`ifdef BC_TIMEOUT_EN
        else begin
          gap_nxt = gap + 8'd1;
          if (gap_nxt == 8'(TIMEOUT)) begin
            state_nxt = DECODE;
            err_nxt   = 1'b1;
            bc_nxt    = frame << (4'd11 - count);
          end
        end
`endif
      end
      DECODE: begin
        state_nxt = IDLE;
        count_nxt = '0;
`ifdef BC_TIMEOUT_EN
        gap_nxt   = '0;
`endif
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      frame     <= '0;
      count     <= '0;
      num       <= '0;
      num_valid <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      bc        <= '0;
`ifdef BC_TIMEOUT_EN
      gap       <= '0;
`endif
    end else begin
      state     <= state_nxt;
      frame     <= frame_nxt;
      count     <= count_nxt;
      num       <= num_nxt;
      num_valid <= num_valid_nxt;
      err       <= err_nxt;
      busy      <= busy_nxt;
      bc        <= bc_nxt;
`ifdef BC_TIMEOUT_EN
      gap       <= gap_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_bc_to_num_decoder.sv
// Scoreboard bench for bc_to_num_decoder: random and directed frames vs a behavioural decode model.
module tb_bc_to_num_decoder;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scan_valid = 1'b0;
  logic        scan_bit = 1'b0;
  logic [3:0]  num;
  logic        num_valid, err, busy;
  logic [10:0] bc;

  bc_to_num_decoder #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .scan_valid(scan_valid), .scan_bit(scan_bit),
    .num(num), .num_valid(num_valid), .err(err), .busy(busy), .bc(bc)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [3:0]  num;
    logic [10:0] bc;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] last_num = '0;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: decode straight from the symbol rules.
  task automatic expect_frame(input logic [10:0] f);
    exp_t e;
    bit ok;
    logic [3:0] n;
    ok = (f[10] == 1'b1) && (f[9] == 1'b0) && (f[0] == 1'b1);
    for (int k = 0; k < 4; k++) begin
      int hi;
      hi = 8 - 2 * k;
      if (f[hi] == 1'b1 && f[hi-1] == 1'b0) n[3-k] = 1'b1;
      else if (f[hi] == 1'b0 && f[hi-1] == 1'b1) n[3-k] = 1'b0;
      else ok = 0;
    end
    if (ok) last_num = n;
    e.is_err = !ok;
    e.num    = last_num;
    e.bc     = f;
    exp_q.push_back(e);
  endtask

  function automatic logic [10:0] encode(input logic [3:0] n);
    logic [10:0] f;
    f = 11'b10000000001;
    for (int k = 0; k < 4; k++) f[2*k+2 -: 2] = n[k] ? 2'b10 : 2'b01;
    return f;
  endfunction

  always @(negedge clk) begin
    if (num_valid || err) begin
      if (num_valid && err) chk("both_pulses", 32'd1, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {bc, num, err}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pulse_kind_err", 32'(err), 32'(e.is_err));
        chk("pulse_num", 32'(num), 32'(e.num));
        chk("pulse_bc", 32'(bc), 32'(e.bc));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_mod(input logic b);
    scan_valid = 1'b1;
    scan_bit   = b;
    tick(1);
    scan_valid = 1'b0;
    scan_bit   = 1'b0;
  endtask

  // lead: quiet-zone zeros first; poke: present a module in the decode cycle.
  task automatic send_frame(input logic [10:0] f, input int gap, input int lead, input bit poke);
    expect_frame(f);
    for (int i = 0; i < lead; i++) send_mod(1'b0);
    for (int i = 10; i >= 0; i--) begin
      send_mod(f[i]);
      if (i > 0) tick(gap);
    end
    chk("busy_pulse_cycle", 32'(busy), 32'd1);
    if (poke) begin
      scan_valid = 1'b1;
      scan_bit   = 1'b1;
    end
    tick(1);
    scan_valid = 1'b0;
    scan_bit   = 1'b0;
    chk("busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("rst_num", 32'(num), 32'd0);
    chk("rst_bc", 32'(bc), 32'd0);
    chk("rst_flags", {busy, num_valid, err}, 32'd0);

    send_frame(11'b10011001101, 0, 0, 1'b0);
    send_frame(11'b10010101011, 0, 0, 1'b0);
    tick(3);
    send_frame(11'b10101010101, 0, 0, 1'b1);
    send_frame(11'b10111001101, 0, 0, 1'b0);
    send_frame(11'b10011001101, 2, 5, 1'b0);

    // Reset mid-frame: partial frame must vanish without a pulse.
    for (int i = 10; i > 4; i--) send_mod(encode(4'd5)[i]);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    last_num = '0;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    send_frame(11'b10100110011, 0, 0, 1'b0);

`ifdef BC_TIMEOUT_EN
    begin
      exp_t e;
      e.is_err = 1'b1;
      e.num    = last_num;
      e.bc     = 11'b10011000000;
      exp_q.push_back(e);
      send_mod(1'b1); send_mod(1'b0); send_mod(1'b0); send_mod(1'b1); send_mod(1'b1);
      tick(TIMEOUT + 2);
      chk("timeout_busy", 32'(busy), 32'd0);
      chk("timeout_pending", 32'(exp_q.size()), 32'd0);
      chk("timeout_num", 32'(num), 32'(last_num));
    end
`else
    send_frame(encode(4'd9), 20, 0, 1'b0);
`endif

    for (int t = 0; t < 40; t++) begin
      logic [10:0] f;
      f = encode(4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) f[$urandom_range(0, 9)] ^= 1'b1;
      send_frame(f, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      tick($urandom_range(0, 2));
    end

    tick(5);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d checks so far", checks);
    $fatal(1, "watchdog");
  end
endmodule
